pc_gen: RTL

//   Parametrised program-counter generator; successor to the fixed 32-bit PC.

---
 rtl/pc_gen_pkg.sv | 18 +
 rtl/pc_gen_ras_stack.sv | 67 ++++++
 rtl/pc_gen.sv | 96 +++++++++
 3 files changed

// File: rtl/pc_gen_pkg.sv
// Shared constants and types for the program-counter generator and its return-address stack.
package pc_gen_pkg;

    localparam logic RSTN_ENABLE = 1'b0;
    localparam logic JUMP_ENABLE = 1'b1;
    localparam logic TRAP_ENABLE = 1'b1;
    localparam logic PC_HOLD     = 1'b1;

    typedef enum logic [2:0] {
        PC_SRC_TRAP,
        PC_SRC_JUMP,
        PC_SRC_RET,
        PC_SRC_HOLD,
        PC_SRC_ADVANCE,
        PC_SRC_IDLE
    } pc_src_e;

endpackage

// File: rtl/pc_gen_ras_stack.sv
// Circular return-address stack: push overwrites the oldest entry when full,
// pop on empty is reported as underflow and leaves the stack untouched.
module ras_stack
    import pc_gen_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top_data,
    output logic              pop_valid,
    output logic              empty,
    output logic              underflow
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(RAS_DEPTH);

    logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
    logic [ADDR_W-1:0] mem_d [RAS_DEPTH];
    logic [PTR_W-1:0]  top_q, top_d, top_inc;
    logic [PTR_W:0]    count_q, count_d;

    assign empty     = (count_q == '0);
    assign pop_valid = pop & ~empty;
    assign underflow = pop & empty;
    assign top_data  = mem_q[top_q];
    assign top_inc   = top_q + 1'b1;

    always_comb begin
        mem_d   = mem_q;
        top_d   = top_q;
        count_d = count_q;
        if (push && pop_valid) begin
            // Return consumes the old top while the call takes its slot.
            mem_d[top_q] = push_data;
        end else if (push) begin
            top_d        = top_inc;
            mem_d[top_inc] = push_data;
            if (count_q != DEPTH_CNT) begin
                count_d = count_q + 1'b1;
            end
        end else if (pop_valid) begin
            top_d   = top_q - 1'b1;
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == RSTN_ENABLE) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            top_q   <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            top_q   <= top_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: trap > jump > ret > hold > advance priority,
// fetch handshake, and return-address prediction through ras_stack.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int              ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int              STEP      = 4,
    parameter int              RAS_DEPTH = 4
) (
    input  logic              i_Clk,
    input  logic              i_reset_n,
    input  logic              i_hold_flag,
    input  logic              i_jump_flag,
    input  logic [ADDR_W-1:0] i_jump_addr,
    input  logic              i_trap_flag,
    input  logic [ADDR_W-1:0] i_trap_vec,
    input  logic              i_call_flag,
    input  logic [ADDR_W-1:0] i_link_addr,
    input  logic              i_ret_flag,
    input  logic              i_fetch_ready,
    output logic [ADDR_W-1:0] o_pc_addr,
    output logic              o_pc_valid,
    output logic              o_ras_empty,
    output logic              o_ras_underflow
);

    localparam int                ALIGN_W    = $clog2(STEP);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = {ADDR_W{1'b1}} << ALIGN_W;
    localparam logic [ADDR_W-1:0] STEP_INC   = ADDR_W'(STEP);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_pop_valid;
    logic              ras_underflow;
    pc_src_e           pc_src;

    ras_stack #(
        .ADDR_W   (ADDR_W),
        .RAS_DEPTH(RAS_DEPTH)
    ) u_ras (
        .clk      (i_Clk),
        .rst_n    (i_reset_n),
        .push     (i_call_flag),
        .pop      (i_ret_flag),
        .push_data(i_link_addr),
        .top_data (ras_top),
        .pop_valid(ras_pop_valid),
        .empty    (o_ras_empty),
        .underflow(ras_underflow)
    );

    always_comb begin
        pc_src = PC_SRC_IDLE;
        if (i_trap_flag == TRAP_ENABLE) begin
            pc_src = PC_SRC_TRAP;
        end else if (i_jump_flag == JUMP_ENABLE) begin
            pc_src = PC_SRC_JUMP;
        end else if (ras_pop_valid) begin
            pc_src = PC_SRC_RET;
        end else if (i_hold_flag == PC_HOLD) begin
            pc_src = PC_SRC_HOLD;
        end else if (valid_q && i_fetch_ready) begin
            pc_src = PC_SRC_ADVANCE;
        end
    end

    always_comb begin
        pc_d    = pc_q;
        valid_d = 1'b1;
        unique case (pc_src)
            PC_SRC_TRAP:    pc_d = i_trap_vec & ALIGN_MASK;
            PC_SRC_JUMP:    pc_d = i_jump_addr & ALIGN_MASK;
            PC_SRC_RET:     pc_d = ras_top & ALIGN_MASK;
            PC_SRC_ADVANCE: pc_d = pc_q + STEP_INC;
            default:        pc_d = pc_q;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_reset_n) begin
        if (i_reset_n == RSTN_ENABLE) begin
            pc_q    <= RESET_VEC;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    assign o_pc_addr  = pc_q;
    assign o_pc_valid = valid_q;
    // Held low in reset so a stray ret during reset does not look like an underflow.
    assign o_ras_underflow = ras_underflow & i_reset_n;

endmodule
